// File: rtl/cnt_job_sequencer.sv
// Job sequencer for the ring counter: queues count requests and issues them one at a time,
// keeping enable low for a fixed gap between jobs and flagging a counter that never finishes.
module cnt_job_sequencer #(
    parameter int CNT_W     = 8,
    parameter int DEPTH     = 4,
    parameter int GAP_CYC   = 2,
    parameter int WD_MARGIN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [CNT_W-1:0]         req_num_i,
    output logic                     cnt_en_o,
    output logic [CNT_W-1:0]         cnt_num_o,
    input  logic                     cnt_done_i,
    output logic                     job_done_o,
    output logic                     wd_err_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   fifo_lvl_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;

    logic [CNT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [LW-1:0]    r_lvl;

    state_t           r_state;
    logic [CNT_W-1:0] r_num;
    logic             r_en;
    logic             r_done;
    logic             r_err;
    logic [CNT_W:0]   r_wd;
    logic [GW-1:0]    r_gap;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W:0]   w_wd_lim;
    logic [CNT_W:0]   w_wd_nxt;

    // Ready is based on the pre-pop level, so a full FIFO never accepts even when popping.
    assign w_full   = (r_lvl == LW'(DEPTH));
    assign w_push   = req_valid_i & ~w_full;
    assign w_pop    = (r_state == S_IDLE) && (r_lvl != '0);
    assign w_wd_lim = {1'b0, r_num} + (CNT_W+1)'(WD_MARGIN);
    assign w_wd_nxt = r_wd + 1'b1;

    assign req_ready_o = ~w_full;
    assign fifo_lvl_o  = r_lvl;
    assign busy_o      = (r_state != S_IDLE) || (r_lvl != '0);
    assign cnt_en_o    = r_en;
    assign cnt_num_o   = r_num;
    assign job_done_o  = r_done;
    assign wd_err_o    = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= req_num_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_lvl <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_lvl <= r_lvl + 1'b1;
                2'b01:   r_lvl <= r_lvl - 1'b1;
                default: r_lvl <= r_lvl;
            endcase
        end
    end

    // Watchdog limit is compared one bit wider than the count so num+margin cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wd    <= '0;
            r_gap   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_num   <= r_mem[r_rp];
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_num == '0) begin
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_en    <= 1'b1;
                        r_wd    <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt_done_i) begin
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else if (w_wd_nxt >= w_wd_lim) begin
                        r_err   <= 1'b1;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_wd <= w_wd_nxt;
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(GAP_CYC - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_job_sequencer.sv
// Directed bench for cnt_job_sequencer: stimulus queues expected jobs, a negedge monitor
// retires them against job_done_o; a small counter model answers enable with done.
module tb_cnt_job_sequencer;

    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic [CNT_W-1:0] req_num = '0;
    logic             m_done = 1'b0;
    logic             f_done = 1'b0;
    logic             w_cnt_done;
    logic             req_ready;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_num;
    logic             job_done;
    logic             wd_err;
    logic             busy;
    logic [2:0]       fifo_lvl;

    assign w_cnt_done = m_done | f_done;

    cnt_job_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH), .GAP_CYC(2), .WD_MARGIN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_num_i   (req_num),
        .cnt_en_o    (cnt_en),
        .cnt_num_o   (cnt_num),
        .cnt_done_i  (w_cnt_done),
        .job_done_o  (job_done),
        .wd_err_o    (wd_err),
        .busy_o      (busy),
        .fifo_lvl_o  (fifo_lvl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] num;
        logic             wd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   model_on = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Counter model: done asserts once enable has been high for cnt_num cycles.
    initial begin : counter_model
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!cnt_en) begin
                cyc = 0;
                m_done = 1'b0;
            end else begin
                cyc++;
                m_done = model_on && (cyc >= int'(cnt_num));
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic prev_jd;
        prev_jd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && job_done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL job_done_unexpected: got pulse, required none (num=%0d)", cnt_num);
                end else begin
                    e = exp_q.pop_front();
                    check("job_num", 32'(cnt_num), 32'(e.num));
                    check("job_wd_err", 32'(wd_err), 32'(e.wd));
                    check("job_en_low", 32'(cnt_en), 0);
                    check("job_done_width", 32'(prev_jd), 0);
                end
            end
            prev_jd = rst_n & job_done;
        end
    end

    task automatic push(input logic [CNT_W-1:0] n, input bit accept, input bit wd);
        req_valid = 1'b1;
        req_num   = n;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (accept) exp_q.push_back({n, wd});
    endtask

    task automatic wait_done(input int lim);
        bit got;
        got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            if (job_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_job_done: got no pulse in %0d cycles, required one", lim);
        end
    endtask

    task automatic wait_en(input int lim);
        bit got;
        got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            if (cnt_en) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_en: got en low for %0d cycles, required high", lim);
        end
    endtask

    task automatic wait_idle(input int lim);
        bit got;
        got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: got busy=%0d pending=%0d, required idle", busy, exp_q.size());
        end
    endtask

    initial begin : time_limit
        #200000;
        $display("FAIL time_limit: got no finish by 200000, required finish");
        $fatal(1, "bench time limit");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", 32'(cnt_en), 0);
        check("rst_num", 32'(cnt_num), 0);
        check("rst_job_done", 32'(job_done), 0);
        check("rst_wd_err", 32'(wd_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_lvl", 32'(fifo_lvl), 0);
        check("rst_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First job: en rises two edges after the push edge.
        push(8'd30, 1'b1, 1'b0);
        check("t1_lvl_push", 32'(fifo_lvl), 1);
        check("t1_en_k", 32'(cnt_en), 0);
        @(posedge clk);
        #1;
        check("t1_en_k1", 32'(cnt_en), 0);
        check("t1_lvl_pop", 32'(fifo_lvl), 0);
        check("t1_num_load", 32'(cnt_num), 30);
        check("t1_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        check("t1_en_k2", 32'(cnt_en), 1);
        check("t1_num_run", 32'(cnt_num), 30);

        // Fill the FIFO while job 30 runs; the fifth request is dropped.
        push(8'd60, 1'b1, 1'b0);
        check("t2_lvl1", 32'(fifo_lvl), 1);
        push(8'd5, 1'b1, 1'b0);
        check("t2_lvl2", 32'(fifo_lvl), 2);
        push(8'd7, 1'b1, 1'b0);
        check("t2_lvl3", 32'(fifo_lvl), 3);
        push(8'd200, 1'b1, 1'b0);
        check("t2_lvl4", 32'(fifo_lvl), 4);
        check("t2_ready_full", 32'(req_ready), 0);
        push(8'd99, 1'b0, 1'b0);
        check("t2_lvl_drop", 32'(fifo_lvl), 4);
        check("t2_en_still", 32'(cnt_en), 1);
        wait_done(100);
        check("t2_gap_en0", 32'(cnt_en), 0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check("t2_gap_en", 32'(cnt_en), 0);
        end
        @(posedge clk);
        #1;
        check("t2_next_en", 32'(cnt_en), 1);
        check("t2_next_num", 32'(cnt_num), 60);
        wait_idle(1500);

        // Zero-count job retires without enabling; the following job runs normally.
        push(8'd0, 1'b1, 1'b0);
        push(8'd5, 1'b1, 1'b0);
        check("t3_en_zero", 32'(cnt_en), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("t3_en_zero", 32'(cnt_en), 0);
        end
        @(posedge clk);
        #1;
        check("t3_next_en", 32'(cnt_en), 1);
        check("t3_next_num", 32'(cnt_num), 5);
        wait_idle(200);

        // Stray done while idle or in the gap has no effect.
        f_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("t5_idle_jd", 32'(job_done), 0);
            check("t5_idle_busy", 32'(busy), 0);
        end
        f_done = 1'b0;
        push(8'd3, 1'b1, 1'b0);
        wait_done(50);
        f_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("t5_gap_jd", 32'(job_done), 0);
            check("t5_gap_en", 32'(cnt_en), 0);
        end
        f_done = 1'b0;
        wait_idle(50);

        // Watchdog: num 10 + margin 4 = 14 RUN cycles without done.
        model_on = 1'b0;
        push(8'd10, 1'b1, 1'b1);
        wait_en(10);
        repeat (13) begin
            @(posedge clk);
            #1;
        end
        check("t4_wd_before", 32'(wd_err), 0);
        check("t4_en_before", 32'(cnt_en), 1);
        @(posedge clk);
        #1;
        check("t4_wd_fire", 32'(wd_err), 1);
        check("t4_jd_fire", 32'(job_done), 1);
        check("t4_en_fire", 32'(cnt_en), 0);
        repeat (5) @(posedge clk);
        #1;
        check("t4_wd_sticky", 32'(wd_err), 1);
        model_on = 1'b1;
        push(8'd4, 1'b1, 1'b1);
        wait_idle(100);
        check("t4_wd_sticky2", 32'(wd_err), 1);

        // Reset mid-RUN with three requests queued.
        push(8'd50, 1'b1, 1'b1);
        wait_en(10);
        push(8'd6, 1'b0, 1'b0);
        push(8'd7, 1'b0, 1'b0);
        push(8'd8, 1'b0, 1'b0);
        check("t6_lvl_pre", 32'(fifo_lvl), 3);
        check("t6_en_pre", 32'(cnt_en), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_en_async", 32'(cnt_en), 0);
        check("t6_lvl_async", 32'(fifo_lvl), 0);
        check("t6_ready_async", 32'(req_ready), 1);
        check("t6_wd_clear", 32'(wd_err), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_num_clear", 32'(cnt_num), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ready_post", 32'(req_ready), 1);
        check("t6_lvl_post", 32'(fifo_lvl), 0);
        push(8'd9, 1'b1, 1'b0);
        wait_idle(100);
        check("t6_wd_post", 32'(wd_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
